// File: rtl/ysyx_24110015_arb_pkg.sv
// ysyx_24110015_arb_pkg: shared FSM encoding and owner ids for the memory arbiter
package ysyx_24110015_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LSU = 1'b1;
endpackage

// File: rtl/ysyx_24110015_arb_grant.sv
// ysyx_24110015_arb_grant: picks a master; round-robin when YSYX_24110015_ARB_RR_EN is defined, else LSU over IFU
module ysyx_24110015_arb_grant
  import ysyx_24110015_arb_pkg::*;
(
  input  logic       if_valid,
  input  logic       lsu_valid,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       owner
);
  logic pick_lsu;
`ifdef YSYX_24110015_ARB_RR_EN
  assign pick_lsu = lsu_valid & (~if_valid | (last_owner == OWN_IF));
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign pick_lsu = lsu_valid;
`endif
  assign owner = pick_lsu ? OWN_LSU : OWN_IF;
  assign grant = {pick_lsu, if_valid & ~pick_lsu};
endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter: IFU/LSU to single memory port arbiter with response timeout (YSYX_24110015_ARB_RR_EN selects round-robin)
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  state_t state;
  logic owner;
  logic last_owner;
  logic gnt_owner;
  logic [1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic gnt_lsu;
  ysyx_24110015_arb_grant u_grant (
    .if_valid  (if_req_valid),
    .lsu_valid (lsu_req_valid),
    .last_owner(last_owner),
    .grant     (grant),
    .owner     (gnt_owner)
  );
  assign gnt_lsu = gnt_owner == OWN_LSU;
  assign if_req_ready = rst & (state == IDLE) & grant[0];
  assign lsu_req_ready = rst & (state == IDLE) & grant[1];
`ifdef YSYX_24110015_ARB_RR_EN
  // remember who won the last grant so ties alternate
  always_ff @(posedge clk) begin
    if (!rst) last_owner <= OWN_IF;
    else if (state == IDLE && |grant) last_owner <= gnt_owner;
  end
`else
  assign last_owner = OWN_IF;
`endif
  // one-outstanding transaction FSM with registered memory and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_IF;
      cnt <= '0;
      mem_req_valid <= 1'b0;
      mem_addr <= '0;
      mem_wen <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      if_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          state <= REQ;
          owner <= gnt_owner;
          mem_req_valid <= 1'b1;
          mem_addr <= gnt_lsu ? lsu_addr : if_addr;
          mem_wen <= gnt_lsu & lsu_wen;
          mem_wdata <= gnt_lsu ? lsu_wdata : '0;
          mem_wmask <= gnt_lsu ? lsu_wmask : '0;
        end
        REQ: if (mem_req_ready) begin
          state <= WAIT;
          mem_req_valid <= 1'b0;
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp_valid || cnt == CNT_LAST) begin
            state <= RESP;
            resp_rdata <= mem_resp_valid ? mem_rdata : '0;
            resp_err <= ~mem_resp_valid;
            if_resp_valid <= owner == OWN_IF;
            lsu_resp_valid <= owner == OWN_LSU;
          end
        end
        default: begin
          state <= IDLE;
          if_resp_valid <= 1'b0;
          lsu_resp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// tb_ysyx_24110015_mem_arbiter: directed bench with a transaction-level model of the arbiter
module tb_ysyx_24110015_mem_arbiter;
  localparam int TC = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req_valid = 1'b0, if_req_ready, if_resp_valid;
  logic [31:0] if_addr = '0;
  logic lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic lsu_wen = 1'b0;
  logic [3:0] lsu_wmask = '0;
  logic [31:0] resp_rdata;
  logic resp_err;
  logic mem_req_valid, mem_wen;
  logic mem_req_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  logic mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr), .if_resp_valid(if_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] win(input logic iv, input logic lv, input logic last);
    logic l;
`ifdef YSYX_24110015_ARB_RR_EN
    l = lv && (!iv || last == 1'b0);
`else
    l = lv;
`endif
    return {l, iv && !l};
  endfunction

  // masters hold a request until handshaken; slave applies stall/latency knobs
  int if_left = 0, lsu_left = 0, stall = 0, s_delay = 1, left = 0;
  bit force_resp = 0;
  logic [31:0] s_rdata = '0;
  bit if_hs, lsu_hs, acc_seen;
  always @(negedge clk) begin
    if_hs = if_req_valid && if_req_ready;
    lsu_hs = lsu_req_valid && lsu_req_ready;
    acc_seen = rst && mem_req_valid && mem_req_ready;
  end
  always @(posedge clk) begin
    #1;
    if (if_hs) if_left--;
    if (lsu_hs) lsu_left--;
    if_req_valid = if_left > 0;
    lsu_req_valid = lsu_left > 0;
    mem_req_ready = !(mem_req_valid && stall > 0);
    if (mem_req_valid && stall > 0) stall--;
    if (!rst) left = 0;
    else if (acc_seen) left = s_delay;
    mem_resp_valid = force_resp || left == 1;
    mem_rdata = left == 1 ? s_rdata : 32'hBAD0_BAD0;
    if (left > 0) left--;
  end

  // transaction model: a pending request, its accept cycle and its decided outcome
  bit tx = 0, acc = 0, dec = 0, own_l = 0, last_l = 0, wd_chk = 1;
  int k = 0, acc_k = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic m_wen = 1'b0, m_err = 1'b0;
  logic [3:0] m_wmask = '0;
  logic [1:0] mw;
  always @(posedge clk) begin
    k++;
    mw = win(if_req_valid, lsu_req_valid, last_l);
    if (!rst) begin
      tx = 0; acc = 0; dec = 0; own_l = 0; last_l = 0; wd_chk = 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_wen = 0; m_err = 0; m_wmask = '0;
    end else if (tx && !acc) begin
      if (mem_req_ready) begin acc = 1; acc_k = k; end
    end else if (tx && !dec) begin
      if (mem_resp_valid) begin m_rdata = mem_rdata; m_err = 0; dec = 1; end
      else if (k - acc_k == TC) begin m_rdata = '0; m_err = 1; dec = 1; end
    end else if (tx) begin
      tx = 0;
    end else if (mw != 2'b00) begin
      tx = 1; acc = 0; dec = 0;
      own_l = mw[1]; last_l = mw[1];
      if (mw[1]) begin
        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask; wd_chk = 1;
      end else begin
        m_addr = if_addr; m_wen = 0; m_wmask = '0; wd_chk = 0;
      end
    end
  end

  logic [1:0] cw;
  always @(negedge clk) if (chk_en) begin
    cw = win(if_req_valid, lsu_req_valid, last_l);
    chk("if_req_ready", if_req_ready, rst && !tx && cw[0]);
    chk("lsu_req_ready", lsu_req_ready, rst && !tx && cw[1]);
    chk("mem_req_valid", mem_req_valid, tx && !acc);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wen", mem_wen, m_wen);
    chk("mem_wmask", mem_wmask, m_wmask);
    if (wd_chk) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_resp_valid", if_resp_valid, tx && dec && !own_l);
    chk("lsu_resp_valid", lsu_resp_valid, tx && dec && own_l);
    chk("resp_rdata", resp_rdata, m_rdata);
    chk("resp_err", resp_err, m_err);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pulse(input bit lsu, input string name, input int exp_n);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      hit = lsu ? lsu_resp_valid : if_resp_valid;
    end
    chk(name, n, exp_n);
  endtask

  bit seen;
  initial begin
    tick(2);
    rst = 1; chk_en = 1;
    @(negedge clk);
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset mem_addr", mem_addr, 0);
    tick(1);
    // IFU read; LSU-side write fields are deliberately live to expose leakage
    lsu_wen = 1; lsu_wmask = 4'hF; lsu_wdata = 32'h5555_AAAA;
    s_delay = 1; s_rdata = 32'h0000_0413; if_addr = 32'h8000_0000;
    if_left = 1; if_req_valid = 1;
    wait_pulse(0, "ifu read latency", 4);
    chk("ifu read rdata", resp_rdata, 32'h0000_0413);
    chk("ifu read err", resp_err, 0);
    chk("ifu read wen", mem_wen, 0);
    chk("ifu read wmask", mem_wmask, 0);
    chk("ifu read addr", mem_addr, 32'h8000_0000);
    tick(1);
    // LSU write
    lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; lsu_wen = 1;
    s_rdata = 32'h0000_0000; lsu_left = 1; lsu_req_valid = 1;
    wait_pulse(1, "lsu write latency", 4);
    chk("lsu write addr", mem_addr, 32'h8000_1000);
    chk("lsu write wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("lsu write wmask", mem_wmask, 4'b0011);
    chk("lsu write wen", mem_wen, 1);
    chk("lsu write no ifu pulse", if_resp_valid, 0);
    tick(1);
    // slave back-pressure for 5 cycles
    stall = 5; s_rdata = 32'h1234_5678; if_addr = 32'h8000_0004;
    if_left = 1; if_req_valid = 1;
    wait_pulse(0, "backpressure latency", 9);
    chk("backpressure rdata", resp_rdata, 32'h1234_5678);
    tick(1);
    // timeout, then a stray response while idle
    s_delay = 0; lsu_wen = 0; lsu_wmask = '0; lsu_addr = 32'h8000_2000;
    lsu_left = 1; lsu_req_valid = 1;
    wait_pulse(1, "timeout latency", 11);
    chk("timeout err", resp_err, 1);
    chk("timeout rdata", resp_rdata, 0);
    tick(1);
    s_rdata = 32'h7777_7777; force_resp = 1;
    tick(1);
    force_resp = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen |= if_resp_valid | lsu_resp_valid;
    end
    chk("late resp ignored", seen, 0);
    tick(1);
    // conflict after reset so the round-robin history starts from IFU
    rst = 0;
    tick(1);
    rst = 1;
    s_delay = 1; s_rdata = 32'hCAFE_0001;
    if_addr = 32'h8000_0100; lsu_addr = 32'h8000_0200;
    lsu_left = 2; if_left = 1; lsu_req_valid = 1; if_req_valid = 1;
    wait_pulse(1, "conflict first lsu", 4);
    chk("conflict first addr", mem_addr, 32'h8000_0200);
`ifdef YSYX_24110015_ARB_RR_EN
    wait_pulse(0, "conflict rr ifu", 4);
    chk("conflict rr ifu addr", mem_addr, 32'h8000_0100);
    wait_pulse(1, "conflict rr lsu", 4);
    chk("conflict rr lsu addr", mem_addr, 32'h8000_0200);
`else
    wait_pulse(1, "conflict second lsu", 4);
    chk("conflict second addr", mem_addr, 32'h8000_0200);
    wait_pulse(0, "conflict ifu last", 4);
    chk("conflict ifu addr", mem_addr, 32'h8000_0100);
`endif
    tick(1);
    // reset while waiting on a silent slave
    s_delay = 0; if_addr = 32'h8000_0300; if_left = 1; if_req_valid = 1;
    tick(4);
    rst = 0;
    tick(1);
    rst = 1;
    @(negedge clk);
    chk("midreset mem_req_valid", mem_req_valid, 0);
    chk("midreset mem_addr", mem_addr, 0);
    chk("midreset resp_rdata", resp_rdata, 0);
    chk("midreset resp_err", resp_err, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= if_resp_valid | lsu_resp_valid;
    end
    chk("midreset no pulse", seen, 0);
    tick(1);
    s_delay = 1; s_rdata = 32'h0000_0513; if_addr = 32'h8000_0400;
    if_left = 1; if_req_valid = 1;
    wait_pulse(0, "post-reset ifu latency", 4);
    chk("post-reset ifu rdata", resp_rdata, 32'h0000_0513);
    chk("post-reset ifu addr", mem_addr, 32'h8000_0400);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_24110015_mem_arbiter.md
# ysyx_24110015_mem_arbiter

Two-master, one-slave memory arbiter that sits directly downstream of the core's instruction fetch unit and load/store path, merging their requests onto the single shared memory port. It holds one transaction outstanding at a time, routes the response back to the originating master, and enforces a response timeout. It replaces the fixed-latency direct memory hookup, so the core's IFU and EXU can tolerate variable-latency memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, max cycles in WAIT before error response (must be ≥ 2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_req_valid / if_req_ready  in / out  1  IFU request handshake (read-only master)
- if_addr  in  ADDR_W  IFU fetch address
- if_resp_valid  out  1  one-cycle pulse: IFU response
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W;  lsu_wen  in  1;  lsu_wdata  in  DATA_W;  lsu_wmask  in  DATA_W/8
- lsu_resp_valid  out  1  one-cycle pulse: LSU response
- resp_rdata  out  DATA_W  read data, shared by both masters, valid with a resp pulse
- resp_err  out  1  timeout flag, valid with a resp pulse
- mem_req_valid / mem_req_ready  out / in  1  slave request handshake
- mem_addr  out  ADDR_W;  mem_wen  out  1;  mem_wdata  out  DATA_W;  mem_wmask  out  DATA_W/8
- mem_resp_valid  in  1;  mem_rdata  in  DATA_W  slave response (no back-pressure)

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any req_valid is high, grant one master. The winner's req_ready is high for that cycle (combinational from state and valids). Register its addr/wen/wdata/wmask and owner id, then go to REQ. The loser's ready stays low, and its request must be held stable.
- Default arbitration: fixed priority, LSU over IFU.
- IFU requests are forced to wen=0 and wmask=0.
- REQ: mem_req_valid=1 with the registered fields. When mem_req_ready=1, go to WAIT and clear the timeout counter.
- WAIT: the counter increments each cycle.
  - When mem_resp_valid=1, capture mem_rdata, set err=0, go to RESP.
  - Otherwise, when counter == TIMEOUT_CYC-1, set rdata=0, err=1, go to RESP.
  - If mem_resp_valid and the timeout coincide, the response wins (err=0).
- RESP: the owner's resp_valid=1 for exactly one cycle, with resp_rdata/resp_err held. Go to IDLE. Masters must accept without stalling.
- mem_resp_valid outside WAIT is ignored. The slave must not respond to a transaction after it has timed out; that is a system constraint and is not checked.
- Reset (rst=0) clears: state=IDLE, all valid/ready outputs 0, resp_rdata=0, resp_err=0, mem_* fields 0, counter 0. This applies mid-transaction: any in-flight transaction is abandoned without a response.

## Timing
- Zero-wait slave (mem_req_ready=1, mem_resp_valid the cycle after acceptance): grant at T0, mem_req_valid at T1, response captured at T2, resp pulse at T3. Best-case latency is 3 cycles request-to-response.
- Next grant is possible at T4. Throughput is at most 1 transaction per 4 cycles.
- Timeout response pulse arrives TIMEOUT_CYC+1 cycles after the mem request is accepted.
- All outputs except the two req_ready signals are registered.

## Configuration
- YSYX_24110015_ARB_RR_EN defined: round-robin arbitration. A registered last_owner bit decides ties: when both masters are valid, the one that was not last granted wins. last_owner resets to IFU, so the first conflict goes to the LSU.
- Undefined: fixed LSU-over-IFU priority, and no last_owner register exists.

## Structure
- Shared package ysyx_24110015_arb_pkg holds:
  - the state enum (IDLE/REQ/WAIT/RESP, 2 bits)
  - owner id constants OWN_IF=0, OWN_LSU=1
- One sub-module, ysyx_24110015_arb_grant: combinational grant logic (two valids and last_owner in; grant vector and owner id out). It contains the macro-dependent policy.
- FSM, datapath registers and timeout counter live in the top module. The counter width is $clog2(TIMEOUT_CYC+1).

## Test plan
- Single IFU read: if_addr=0x8000_0000, slave returns 0x0000_0413 one cycle after accept → if_resp_valid at T3, resp_rdata=0x0000_0413, resp_err=0; mem_wen=0, mem_wmask=0.
- LSU write: lsu_addr=0x8000_1000, wdata=0xDEAD_BEEF, wmask=4'b0011 → mem fields match exactly; lsu_resp_valid pulses once; if_resp_valid stays 0.
- Conflict: both masters valid in the same cycle → without the macro, LSU is granted first and IFU after LSU's RESP. With the macro, two back-to-back conflicts alternate LSU, IFU.
- Slave back-pressure: mem_req_ready low for 5 cycles → mem_req_valid and mem_addr held stable; the response still arrives correctly.
- Timeout: TIMEOUT_CYC=8, slave never responds → resp pulse 9 cycles after accept with resp_err=1 and resp_rdata=0. A late mem_resp_valid in IDLE is ignored.
- Reset mid-WAIT: rst=0 for 1 cycle → no resp pulse; all outputs 0; a fresh IFU request afterwards completes normally.
